// File: rtl/ssd_pkg.sv
// Shared constants, phase encoding and select helper for the seven-segment scan controller.
package ssd_pkg;

    localparam int unsigned SSD_DEF_DIGITS  = 4;
    localparam int unsigned SSD_DEF_DIGIT_W = 4;
    localparam int unsigned SSD_MAX_DIGITS  = 16;
    localparam logic [SSD_DEF_DIGIT_W-1:0] SSD_BLANK_CODE = '1;
    localparam logic SSD_SEL_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        PH_GUARD = 2'd0,
        PH_LIT   = 2'd1,
        PH_DARK  = 2'd2
    } phase_e;

    // Digit idx of n maps to select bit n-1-idx; every other bit stays inactive.
    function automatic logic [SSD_MAX_DIGITS-1:0] one_cold(input int unsigned idx,
                                                           input int unsigned n);
        logic [SSD_MAX_DIGITS-1:0] sel;
        sel = '1;
        if (idx < n) sel[n-1-idx] = SSD_SEL_ACTIVE;
        return sel;
    endfunction

endpackage

// File: rtl/ssd_scan_ctl_n_if.sv
// Bundle between the display data path (master) and the scan controller (slave).
interface ssd_scan_ctl_n_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIGIT_W    = 4,
    parameter int unsigned BRIGHT_W   = 10
);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic [NUM_DIGITS*DIGIT_W-1:0] digits_in;
    logic [NUM_DIGITS-1:0]         digit_en;
    logic [BRIGHT_W-1:0]           brightness;
    logic [NUM_DIGITS-1:0]         ssd_ctl;
    logic [DIGIT_W-1:0]            ssd_in;
    logic [IDX_W-1:0]              scan_idx;
    logic                          frame_start;

    modport master (
        output digits_in, digit_en, brightness,
        input  ssd_ctl, ssd_in, scan_idx, frame_start
    );

    modport slave (
        input  digits_in, digit_en, brightness,
        output ssd_ctl, ssd_in, scan_idx, frame_start
    );
endinterface

// File: rtl/ssd_slot_timer.sv
// Per-slot prescaler and phase decode (guard / lit / dark) for the scan controller.
module ssd_slot_timer
    import ssd_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned GUARD_CYCLES = 50,
    parameter int unsigned BRIGHT_W     = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BRIGHT_W-1:0] bright,
    output phase_e              phase_c,
    output logic                slot_wrap_c
);
    localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    logic [CNT_W-1:0] slot_cnt;

    assign slot_wrap_c = (32'(slot_cnt) == DWELL_CYCLES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
        end else if (slot_wrap_c) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Post-guard offset never reaches the window end, so the lit test saturates by itself.
    always_comb begin
        phase_c = PH_DARK;
        if (32'(slot_cnt) + 32'd1 <= GUARD_CYCLES) begin
            phase_c = PH_GUARD;
        end else if (32'(slot_cnt) - GUARD_CYCLES < 32'(bright)) begin
            phase_c = PH_LIT;
        end
    end

endmodule

// File: rtl/ssd_scan_ctl_n.sv
// Multiplexed seven-segment scan controller: digit index, frame snapshot and registered pin drive.
module ssd_scan_ctl_n
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = SSD_DEF_DIGITS,
    parameter int unsigned DIGIT_W      = SSD_DEF_DIGIT_W,
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned GUARD_CYCLES = 50,
    parameter int unsigned BRIGHT_W     = 10,
    parameter logic [DIGIT_W-1:0] BLANK_VAL = {DIGIT_W{1'b1}}
) (
    input logic             clk,
    input logic             rst_n,
    ssd_scan_ctl_n_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned BUS_W = NUM_DIGITS * DIGIT_W;

    logic [IDX_W-1:0]          idx;
    logic                      frame_first;
    logic [BUS_W-1:0]          dig_snap, dig_eff;
    logic [NUM_DIGITS-1:0]     en_snap, en_eff;
    logic [BRIGHT_W-1:0]       bright_snap, bright_eff;
    phase_e                    phase_c;
    logic                      slot_wrap_c;
    logic [SSD_MAX_DIGITS-1:0] sel;
    logic [NUM_DIGITS-1:0]     ctl_nx;
    logic [DIGIT_W-1:0]        din_nx;

    // The frame's first cycle already uses the values being captured on that edge.
    assign dig_eff    = frame_first ? bus.digits_in  : dig_snap;
    assign en_eff     = frame_first ? bus.digit_en   : en_snap;
    assign bright_eff = frame_first ? bus.brightness : bright_snap;

    ssd_slot_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .GUARD_CYCLES (GUARD_CYCLES),
        .BRIGHT_W     (BRIGHT_W)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .bright      (bright_eff),
        .phase_c     (phase_c),
        .slot_wrap_c (slot_wrap_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            frame_first <= 1'b1;
            dig_snap    <= '0;
            en_snap     <= '0;
            bright_snap <= '0;
        end else begin
            if (frame_first) begin
                dig_snap    <= bus.digits_in;
                en_snap     <= bus.digit_en;
                bright_snap <= bus.brightness;
            end
            if (slot_wrap_c) begin
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end
            frame_first <= slot_wrap_c && (idx == IDX_W'(NUM_DIGITS - 1));
        end
    end

    always_comb begin
        ctl_nx = '1;
        din_nx = BLANK_VAL;
        sel    = one_cold(32'(idx), NUM_DIGITS);
        if (phase_c == PH_LIT && en_eff[idx]) begin
            ctl_nx = sel[NUM_DIGITS-1:0];
            din_nx = dig_eff[32'(idx)*DIGIT_W +: DIGIT_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ssd_ctl     <= '1;
            bus.ssd_in      <= BLANK_VAL;
            bus.scan_idx    <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.ssd_ctl     <= ctl_nx;
            bus.ssd_in      <= din_nx;
            bus.scan_idx    <= idx;
            bus.frame_start <= frame_first;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctl_n.sv
// Bench for ssd_scan_ctl_n: 4-digit/guard-2 and 3-digit/guard-0 instances against a frame-position model.
module tb_ssd_scan_ctl_n;

    localparam int unsigned DW = 8;

    typedef struct packed {
        logic        fs;
        logic [3:0]  idx;
        logic [15:0] ctl;
        logic [3:0]  din;
    } exp_t;

    logic clk;
    logic rst_n;
    logic cmp_en;
    int   n_checks;
    int   n_err;

    logic [15:0] dig;
    logic [3:0]  en;
    logic [3:0]  br;

    ssd_scan_ctl_n_if #(.NUM_DIGITS(4), .DIGIT_W(4), .BRIGHT_W(4)) if1 ();
    ssd_scan_ctl_n_if #(.NUM_DIGITS(3), .DIGIT_W(4), .BRIGHT_W(4)) if2 ();

    assign if1.digits_in  = dig;
    assign if1.digit_en   = en;
    assign if1.brightness = br;
    assign if2.digits_in  = dig[11:0];
    assign if2.digit_en   = en[2:0];
    assign if2.brightness = br;

    ssd_scan_ctl_n #(.NUM_DIGITS(4), .DIGIT_W(4), .DWELL_CYCLES(DW), .GUARD_CYCLES(2),
                     .BRIGHT_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    ssd_scan_ctl_n #(.NUM_DIGITS(3), .DIGIT_W(4), .DWELL_CYCLES(DW), .GUARD_CYCLES(0),
                     .BRIGHT_W(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output a pin-level observer must see at frame position pos, straight from the scan rules.
    function automatic exp_t model_out(input int n, input int g, input int pos,
                                       input logic [15:0] d, input logic [3:0] e, input int b);
        exp_t r;
        int slot, c, win, on;
        slot  = pos / DW;
        c     = pos % DW;
        win   = DW - g;
        on    = (b < win) ? b : win;
        r.fs  = (pos == 0);
        r.idx = 4'(slot);
        r.ctl = '1;
        r.din = 4'hF;
        if (c >= g && c < g + on && e[slot]) begin
            r.ctl[n-1-slot] = 1'b0;
            r.din = d[slot*4 +: 4];
        end
        return r;
    endfunction

    function automatic exp_t blank_exp();
        exp_t r;
        r.fs  = 1'b0;
        r.idx = '0;
        r.ctl = '1;
        r.din = 4'hF;
        return r;
    endfunction

    int          k1, k2;
    logic [15:0] s1_dig, s2_dig;
    logic [3:0]  s1_en, s2_en;
    int          s1_br, s2_br;
    exp_t        e1, e2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k1 <= 0;
            e1 <= blank_exp();
        end else begin
            k1 <= k1 + 1;
            if (k1 % 32 == 0) begin
                s1_dig <= dig;
                s1_en  <= en;
                s1_br  <= int'(br);
            end
            e1 <= model_out(4, 2, k1 % 32,
                            (k1 % 32 == 0) ? dig : s1_dig,
                            (k1 % 32 == 0) ? en  : s1_en,
                            (k1 % 32 == 0) ? int'(br) : s1_br);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k2 <= 0;
            e2 <= blank_exp();
        end else begin
            k2 <= k2 + 1;
            if (k2 % 24 == 0) begin
                s2_dig <= dig;
                s2_en  <= en;
                s2_br  <= int'(br);
            end
            e2 <= model_out(3, 0, k2 % 24,
                            (k2 % 24 == 0) ? {4'h0, dig[11:0]} : s2_dig,
                            (k2 % 24 == 0) ? {1'b0, en[2:0]}   : s2_en,
                            (k2 % 24 == 0) ? int'(br) : s2_br);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ctl1", 32'(if1.ssd_ctl), 32'(e1.ctl[3:0]));
            chk("din1", 32'(if1.ssd_in), 32'(e1.din));
            chk("idx1", 32'(if1.scan_idx), 32'(e1.idx));
            chk("fs1", 32'(if1.frame_start), 32'(e1.fs));
            chk("onecold1", 32'($countones(~if1.ssd_ctl) <= 1), 32'd1);
            chk("ctl2", 32'(if2.ssd_ctl), 32'(e2.ctl[2:0]));
            chk("din2", 32'(if2.ssd_in), 32'(e2.din));
            chk("idx2", 32'(if2.scan_idx), 32'(e2.idx));
            chk("fs2", 32'(if2.frame_start), 32'(e2.fs));
            chk("onecold2", 32'($countones(~if2.ssd_ctl) <= 1), 32'd1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        cmp_en   = 1'b0;
        dig      = 16'h4321;
        en       = 4'hF;
        br       = 4'd15;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        step(3);
        chk("rst_ctl", 32'(if1.ssd_ctl), 32'hF);
        chk("rst_din", 32'(if1.ssd_in), 32'hF);
        chk("rst_idx", 32'(if1.scan_idx), 32'h0);
        chk("rst_fs", 32'(if1.frame_start), 32'h0);
        cmp_en = 1'b1;
        @(negedge clk) rst_n = 1'b1;

        // Frame 0: basic scan, all digits, full brightness
        step(1);
        chk("e0_fs", 32'(if1.frame_start), 32'h1);
        chk("e0_ctl", 32'(if1.ssd_ctl), 32'hF);
        chk("e0_ctl2", 32'(if2.ssd_ctl), 32'h3);
        chk("e0_din2", 32'(if2.ssd_in), 32'h1);
        step(2);
        chk("e2_ctl", 32'(if1.ssd_ctl), 32'h7);
        chk("e2_din", 32'(if1.ssd_in), 32'h1);
        step(8);
        chk("e10_ctl", 32'(if1.ssd_ctl), 32'hB);
        chk("e10_din", 32'(if1.ssd_in), 32'h2);
        step(14);
        chk("e24_fs2", 32'(if2.frame_start), 32'h1);
        chk("e24_idx2", 32'(if2.scan_idx), 32'h0);
        step(7);
        chk("e31_ctl", 32'(if1.ssd_ctl), 32'hE);
        chk("e31_din", 32'(if1.ssd_in), 32'h4);
        chk("e31_idx", 32'(if1.scan_idx), 32'h3);
        step(1);
        chk("e32_fs", 32'(if1.frame_start), 32'h1);
        chk("e32_idx", 32'(if1.scan_idx), 32'h0);

        // Mid-frame change of digits and brightness must wait for the next frame
        step(12);
        dig = 16'h8765;
        br  = 4'd3;
        step(14);
        chk("tear_ctl", 32'(if1.ssd_ctl), 32'hE);
        chk("tear_din", 32'(if1.ssd_in), 32'h4);
        step(10);
        chk("pwm_lit_ctl", 32'(if1.ssd_ctl), 32'h7);
        chk("pwm_lit_din", 32'(if1.ssd_in), 32'h5);
        step(1);
        chk("pwm_dark_ctl", 32'(if1.ssd_ctl), 32'hF);
        chk("pwm_dark_din", 32'(if1.ssd_in), 32'hF);

        // Digit enable 0101 takes effect in frame 3
        en = 4'b0101;
        br = 4'd15;
        step(37);
        chk("en_off_ctl", 32'(if1.ssd_ctl), 32'hF);
        step(8);
        chk("en_on_ctl", 32'(if1.ssd_ctl), 32'hD);
        chk("en_on_din", 32'(if1.ssd_in), 32'h7);

        // Brightness 0: dark frame while scanning continues
        br = 4'd0;
        step(17);
        chk("b0_ctl_a", 32'(if1.ssd_ctl), 32'hF);
        step(24);
        chk("b0_ctl_b", 32'(if1.ssd_ctl), 32'hF);
        chk("b0_idx", 32'(if1.scan_idx), 32'h3);
        en = 4'hF;
        br = 4'd15;

        // Asynchronous reset while slot 2 is lit
        step(25);
        chk("pre_rst_ctl", 32'(if1.ssd_ctl), 32'hD);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ctl", 32'(if1.ssd_ctl), 32'hF);
        chk("async_din", 32'(if1.ssd_in), 32'hF);
        chk("async_idx", 32'(if1.scan_idx), 32'h0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        step(1);
        chk("rel_fs", 32'(if1.frame_start), 32'h1);
        chk("rel_idx", 32'(if1.scan_idx), 32'h0);
        step(50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctl_n.md
Name: ssd_scan_ctl_n

Overview:
Parametrised multiplexed seven-segment scan controller. It is the successor to the fixed 4-digit scanner and runs on the system clock with an internal refresh prescaler instead of a divided clock.
- Adds per-digit enable, inter-digit ghosting guard, PWM brightness, frame-coherent input snapshot and a frame-start strobe.
- Sits between the display data path (BCD/segment encoders) and the board digit/segment pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; legal range 2..16.
DIGIT_W, 4, width of each digit code and of ssd_in.
DWELL_CYCLES, 1000, clk cycles per digit slot; must be > GUARD_CYCLES.
GUARD_CYCLES, 50, blank cycles at the start of each slot (anti-ghosting); 0 is legal.
BRIGHT_W, 10, width of brightness.
BLANK_VAL, {DIGIT_W{1'b1}}, value driven on ssd_in whenever no digit is lit.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
digits_in  input  NUM_DIGITS*DIGIT_W  digit i occupies bits [i*DIGIT_W +: DIGIT_W].
digit_en  input  NUM_DIGITS  1 = digit i may light; 0 = its slot stays dark.
brightness  input  BRIGHT_W  lit cycles per slot after the guard, saturating.
ssd_ctl  output  NUM_DIGITS  active-low digit select; digit i drives bit NUM_DIGITS-1-i.
ssd_in  output  DIGIT_W  code for the selected digit, or BLANK_VAL.
scan_idx  output  $clog2(NUM_DIGITS)  index of the current slot.
frame_start  output  1  one-cycle pulse on cycle 0 of slot 0.

Behaviour:
- Reset (rst_n=0, asynchronous): ssd_ctl all ones, ssd_in=BLANK_VAL, scan_idx=0, frame_start=0. Slot counter, index and snapshot registers clear to 0.
- Registering: all outputs are registers; no combinational path from inputs to outputs.
- Start-up: the first rising edge after rst_n deasserts produces output cycle 0 of slot 0.
- Slot counter: slot_cnt runs 0..DWELL_CYCLES-1. On wrap, scan_idx increments. scan_idx wraps NUM_DIGITS-1 -> 0, including non-power-of-2 NUM_DIGITS.
- Phase FSM per slot:
  - GUARD: slot_cnt < GUARD_CYCLES. ssd_ctl all ones, ssd_in=BLANK_VAL.
  - LIT: GUARD_CYCLES <= slot_cnt < GUARD_CYCLES+on_len, and en_snap[scan_idx]=1. ssd_ctl bit (NUM_DIGITS-1-scan_idx) = 0, all others 1. ssd_in = snapshot digit scan_idx.
  - DARK: remainder of the slot. Outputs blank.
- on_len = min(bright_snap, DWELL_CYCLES-GUARD_CYCLES).
  - brightness=0: display fully dark, scanning continues.
  - brightness >= DWELL-GUARD: 100% of the post-guard window.
- Snapshot: digits_in, digit_en and brightness are captured on the edge that produces slot 0 cycle 0. The same edge asserts frame_start. Mid-frame input changes have no effect until the next frame (no tearing).
- Disabled digit: its slot time is still consumed, so refresh rate and the brightness of other digits are unchanged.
- Never more than one ssd_ctl bit is low at a time. No cycle exists in which ssd_ctl changes digit without a preceding GUARD cycle, unless GUARD_CYCLES=0.
- Reset mid-slot: outputs blank immediately. Scanning restarts at slot 0 cycle 0 after release.
- Frame period = NUM_DIGITS*DWELL_CYCLES clk cycles.
- frame_start period is exactly the frame period; the first pulse occurs on the first edge after reset.

Decomposition:
- Shared package (ssd_pkg):
  - SSD default constants: blank code, default digit count, active-low select polarity.
  - Helper function: index-to-one-cold select vector.
- One natural sub-module: ssd_slot_timer. It holds the prescaler slot_cnt and the phase decode, and outputs phase and slot_wrap.
- The top module owns the index counter, snapshot registers and output muxing.

Test Plan:
Use NUM_DIGITS=4, DIGIT_W=4, DWELL_CYCLES=8, GUARD_CYCLES=2, BRIGHT_W=4 unless noted.
- Reset and basic scan: digits_in=16'h4321, digit_en=4'hF, brightness=15.
  - Each slot: 2 blank cycles, then 6 lit cycles.
  - ssd_ctl sequence 0111/1011/1101/1110 with ssd_in 1,2,3,4.
  - frame_start every 32 cycles.
- Brightness PWM: brightness=3 -> per slot 2 blank + 3 lit + 3 dark. brightness=0 -> ssd_ctl stays 4'hF forever while scan_idx keeps cycling.
- Digit enable: digit_en=4'b0101 -> only slots 0 and 2 light (ssd_ctl 0111 and 1101). Slots 1 and 3 are blank for all 8 cycles. Frame stays 32 cycles.
- Tearing: change digits_in to 16'h8765 at cycle 12 of a frame -> the current frame still shows 1,2,3,4. The next frame shows 5,6,7,8 from its frame_start.
- Async reset mid-LIT: pull rst_n low between edges during slot 2 -> outputs blank before the next edge. After release, the first edge yields scan_idx=0, frame_start=1.
- Parameter sweep: NUM_DIGITS=3, GUARD_CYCLES=0.
  - scan_idx wraps 2->0.
  - Exactly one ssd_ctl bit is low whenever lit.
  - Frame period is 24 cycles.
